// File: rtl/mod_up_down_counter_pkg.sv
// Shared constants for the up/down modulo counter
// and the colour-sequencing logic that drives it.
package mod_up_down_counter_pkg;

  localparam logic [1:0] MODE_WRAP     = 2'b00;
  localparam logic [1:0] MODE_SAT      = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

endpackage

// File: rtl/mod_up_down_counter_step_prescaler.sv
// Enable-gated prescaler: Tick is high on the
// terminal count while En is high.
module step_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic Clk,
  input  logic reset,
  input  logic En,
  input  logic Clear,
  output logic Tick
);

  if (PRESCALE == 1) begin : g_bypass
    logic unused;
    assign unused = Clk ^ reset ^ Clear;
    assign Tick   = En;
  end else begin : g_cnt
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] TERM =
      CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign Tick = En && (cnt_q == TERM);

    always_comb begin
      cnt_d = cnt_q;
      if (Clear || Tick) begin
        cnt_d = '0;
      end else if (En) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

endmodule

// File: rtl/mod_up_down_counter.sv
// Up/down modulo counter with wrap, saturate and
// ping-pong end behaviour, prescaler and load.
module mod_up_down_counter #(
  parameter int WIDTH       = 3,
  parameter int MODULUS     = 6,
  parameter int PRESCALE    = 1,
  parameter int RESET_VALUE = 0
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             En,
  input  logic             UpOrDown,
  input  logic [1:0]       Mode,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic [WIDTH-1:0] Count,
  output logic             Step,
  output logic             Wrap,
  output logic             Dir,
  output logic             AtMin,
  output logic             AtMax
);

  import mod_up_down_counter_pkg::*;

  if (MODULUS < 2 || MODULUS > (1 << WIDTH))
  begin : g_bad_modulus
    $error("MODULUS out of range");
  end
  if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS)
  begin : g_bad_reset
    $error("RESET_VALUE must be < MODULUS");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("PRESCALE must be >= 1");
  end

  localparam logic [WIDTH-1:0] MAX =
    WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_COUNT =
    WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] ONE =
    WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;
  logic             ppdir_q, ppdir_d;
  logic             tick;
  logic             is_pp, is_sat;
  logic             at_min, at_max;
  logic [WIDTH-1:0] load_val;

  step_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .Clk   (Clk),
    .reset (reset),
    .En    (En),
    .Clear (Load),
    .Tick  (tick)
  );

  assign is_pp  = (Mode == MODE_PINGPONG);
  assign is_sat = (Mode == MODE_SAT);
  assign at_min = (count_q == '0);
  assign at_max = (count_q == MAX);
  assign Dir    = is_pp ? ppdir_q : UpOrDown;

  assign load_val =
    (int'(LoadValue) >= MODULUS) ? MAX : LoadValue;

  always_comb begin
    count_d = count_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    ppdir_d = ppdir_q;
    if (Load) begin
      count_d = load_val;
      ppdir_d = UpOrDown;
    end else if (tick) begin
      step_d = 1'b1;
      unique case (1'b1)
        is_pp: begin
          if (ppdir_q && at_max) begin
            count_d = MAX - ONE;
            ppdir_d = 1'b0;
            wrap_d  = 1'b1;
          end else if (!ppdir_q && at_min) begin
            count_d = ONE;
            ppdir_d = 1'b1;
            wrap_d  = 1'b1;
          end else if (ppdir_q) begin
            count_d = count_q + ONE;
          end else begin
            count_d = count_q - ONE;
          end
        end
        is_sat: begin
          if (Dir && !at_max) begin
            count_d = count_q + ONE;
          end else if (!Dir && !at_min) begin
            count_d = count_q - ONE;
          end
        end
        default: begin
          // Mode 2'b11 falls through to wrap.
          if (Dir && at_max) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else if (!Dir && at_min) begin
            count_d = MAX;
            wrap_d  = 1'b1;
          end else if (Dir) begin
            count_d = count_q + ONE;
          end else begin
            count_d = count_q - ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      count_q <= RST_COUNT;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
      ppdir_q <= 1'b1;
    end else begin
      count_q <= count_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
      ppdir_q <= ppdir_d;
    end
  end

  assign Count = count_q;
  assign Step  = step_q;
  assign Wrap  = wrap_q;
  assign AtMin = at_min;
  assign AtMax = at_max;

endmodule

// File: tb/tb_mod_up_down_counter.sv
// Directed bench: default counter (a_*) and a
// PRESCALE=3 counter (b_*) sharing stimulus.
module tb_mod_up_down_counter;

  import mod_up_down_counter_pkg::*;

  logic       Clk = 1'b0;
  logic       reset;
  logic       En;
  logic       UpOrDown;
  logic [1:0] Mode;
  logic       Load;
  logic [2:0] LoadValue;

  logic [2:0] a_count, b_count;
  logic a_step, a_wrap, a_dir, a_atmin, a_atmax;
  logic b_step, b_wrap, b_dir, b_atmin, b_atmax;

  int n_chk = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  mod_up_down_counter dut_a (
    .Clk       (Clk),
    .reset     (reset),
    .En        (En),
    .UpOrDown  (UpOrDown),
    .Mode      (Mode),
    .Load      (Load),
    .LoadValue (LoadValue),
    .Count     (a_count),
    .Step      (a_step),
    .Wrap      (a_wrap),
    .Dir       (a_dir),
    .AtMin     (a_atmin),
    .AtMax     (a_atmax)
  );

  mod_up_down_counter #(
    .PRESCALE (3)
  ) dut_b (
    .Clk       (Clk),
    .reset     (reset),
    .En        (En),
    .UpOrDown  (UpOrDown),
    .Mode      (Mode),
    .Load      (Load),
    .LoadValue (LoadValue),
    .Count     (b_count),
    .Step      (b_step),
    .Wrap      (b_wrap),
    .Dir       (b_dir),
    .AtMin     (b_atmin),
    .AtMax     (b_atmax)
  );

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_load(input logic [2:0] v);
    Load = 1'b1;
    LoadValue = v;
    cyc();
    Load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Mode = MODE_PINGPONG;
    cyc();
    n_chk++;
    if (a_count !== 3'd0 || a_step !== 1'b0 ||
        a_wrap !== 1'b0 || a_dir !== 1'b1 ||
        a_atmin !== 1'b1 || a_atmax !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: cnt=%0d st=%b wr=%b dir=%b mn=%b mx=%b want 0 0 0 1 1 0",
               a_count, a_step, a_wrap, a_dir,
               a_atmin, a_atmax);
    end
    reset = 1'b0;
    Mode = MODE_WRAP;
  endtask

  task automatic test_wrap();
    logic [2:0] ec [6] =
      '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    UpOrDown = 1'b1;
    En = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_chk++;
      if (a_count !== ec[i] || a_step !== 1'b1 ||
          a_wrap !== (i == 5)) begin
        n_fail++;
        $display("FAIL wrap_up[%0d]: cnt=%0d st=%b wr=%b want %0d 1 %b",
                 i, a_count, a_step, a_wrap, ec[i],
                 (i == 5));
      end
    end
    UpOrDown = 1'b0;
    cyc();
    n_chk++;
    if (a_count !== 3'd5 || a_wrap !== 1'b1 ||
        a_atmax !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_down: cnt=%0d wr=%b mx=%b want 5 1 1",
               a_count, a_wrap, a_atmax);
    end
    cyc();
    n_chk++;
    if (a_count !== 3'd4 || a_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_down2: cnt=%0d wr=%b want 4 0",
               a_count, a_wrap);
    end
    En = 1'b0;
    cyc();
    n_chk++;
    if (a_count !== 3'd4 || a_step !== 1'b0) begin
      n_fail++;
      $display("FAIL hold: cnt=%0d st=%b want 4 0",
               a_count, a_step);
    end
  endtask

  task automatic test_saturate();
    Mode = MODE_SAT;
    UpOrDown = 1'b0;
    do_load(3'd1);
    n_chk++;
    if (a_count !== 3'd1 || a_step !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_load: cnt=%0d st=%b want 1 0",
               a_count, a_step);
    end
    En = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_chk++;
      if (a_count !== 3'd0 || a_step !== 1'b1 ||
          a_wrap !== 1'b0 || a_atmin !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_down[%0d]: cnt=%0d st=%b wr=%b mn=%b want 0 1 0 1",
                 i, a_count, a_step, a_wrap, a_atmin);
      end
    end
    En = 1'b0;
    do_load(3'd4);
    UpOrDown = 1'b1;
    En = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_chk++;
      if (a_count !== 3'd5 || a_step !== 1'b1 ||
          a_wrap !== 1'b0 || a_atmax !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_up[%0d]: cnt=%0d st=%b wr=%b mx=%b want 5 1 0 1",
                 i, a_count, a_step, a_wrap, a_atmax);
      end
    end
    En = 1'b0;
  endtask

  task automatic test_pingpong();
    logic [2:0] ec [11] =
      '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4,
        3'd3, 3'd2, 3'd1, 3'd0, 3'd1};
    logic ed [11] =
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    Mode = MODE_PINGPONG;
    UpOrDown = 1'b1;
    do_load(3'd0);
    n_chk++;
    if (a_count !== 3'd0 || a_dir !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_load: cnt=%0d dir=%b want 0 1",
               a_count, a_dir);
    end
    UpOrDown = 1'b0;
    En = 1'b1;
    for (int i = 0; i < 11; i++) begin
      cyc();
      n_chk++;
      if (a_count !== ec[i] || a_dir !== ed[i] ||
          a_step !== 1'b1 ||
          a_wrap !== (i == 5 || i == 10)) begin
        n_fail++;
        $display("FAIL pp[%0d]: cnt=%0d dir=%b st=%b wr=%b want %0d %b 1 %b",
                 i, a_count, a_dir, a_step, a_wrap,
                 ec[i], ed[i], (i == 5 || i == 10));
      end
    end
    En = 1'b0;
  endtask

  task automatic test_prescale();
    logic en_s [7] =
      '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [2:0] ec [7] =
      '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2};
    logic es [7] =
      '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    Mode = MODE_WRAP;
    UpOrDown = 1'b1;
    do_load(3'd0);
    for (int i = 0; i < 7; i++) begin
      En = en_s[i];
      cyc();
      n_chk++;
      if (b_count !== ec[i] || b_step !== es[i]) begin
        n_fail++;
        $display("FAIL prescale[%0d]: cnt=%0d st=%b want %0d %b",
                 i, b_count, b_step, ec[i], es[i]);
      end
    end
    En = 1'b0;
  endtask

  task automatic test_load_clamp();
    do_load(3'd7);
    n_chk++;
    if (a_count !== 3'd5 || b_count !== 3'd5 ||
        a_atmax !== 1'b1 || a_step !== 1'b0) begin
      n_fail++;
      $display("FAIL load_clamp: a=%0d b=%0d mx=%b st=%b want 5 5 1 0",
               a_count, b_count, a_atmax, a_step);
    end
  endtask

  task automatic test_load_vs_step();
    logic [2:0] ec [3] = '{3'd2, 3'd2, 3'd3};
    logic es [3] = '{1'b0, 1'b0, 1'b1};
    En = 1'b1;
    cyc();
    cyc();
    Load = 1'b1;
    LoadValue = 3'd2;
    cyc();
    Load = 1'b0;
    n_chk++;
    if (b_count !== 3'd2 || b_step !== 1'b0 ||
        a_count !== 3'd2 || a_step !== 1'b0 ||
        a_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL load_vs_step: b=%0d bst=%b a=%0d ast=%b awr=%b want 2 0 2 0 0",
               b_count, b_step, a_count, a_step,
               a_wrap);
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_chk++;
      if (b_count !== ec[i] || b_step !== es[i]) begin
        n_fail++;
        $display("FAIL after_load[%0d]: cnt=%0d st=%b want %0d %b",
                 i, b_count, b_step, ec[i], es[i]);
      end
    end
    En = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [2:0] ec [3] = '{3'd0, 3'd0, 3'd1};
    Mode = MODE_PINGPONG;
    UpOrDown = 1'b0;
    do_load(3'd4);
    En = 1'b1;
    cyc();
    En = 1'b0;
    n_chk++;
    if (a_count !== 3'd3 || a_dir !== 1'b0 ||
        a_step !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: cnt=%0d dir=%b st=%b want 3 0 1",
               a_count, a_dir, a_step);
    end
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if (a_count !== 3'd0 || a_step !== 1'b0 ||
        a_wrap !== 1'b0 || a_dir !== 1'b1 ||
        b_count !== 3'd0 || b_step !== 1'b0 ||
        b_wrap !== 1'b0 || b_dir !== 1'b1 ||
        b_atmin !== 1'b1 || b_atmax !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: a=%0d st=%b wr=%b dir=%b b=%0d bdir=%b want 0 0 0 1 0 1",
               a_count, a_step, a_wrap, a_dir,
               b_count, b_dir);
    end
    cyc();
    reset = 1'b0;
    Mode = MODE_WRAP;
    UpOrDown = 1'b1;
    En = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_chk++;
      if (b_count !== ec[i]) begin
        n_fail++;
        $display("FAIL post_reset[%0d]: cnt=%0d want %0d",
                 i, b_count, ec[i]);
      end
    end
    En = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    En = 1'b0;
    UpOrDown = 1'b1;
    Mode = MODE_WRAP;
    Load = 1'b0;
    LoadValue = 3'd0;
    test_reset();
    test_wrap();
    test_saturate();
    test_pingpong();
    test_prescale();
    test_load_clamp();
    test_load_vs_step();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
